// File: rtl/branch_predictor_if.sv
// Fetch-stage branch predictor bus: combinational lookup plus resolved-branch training from EX.
interface branch_predictor_if;
  logic [31:0] lookup_pc_i;
  logic        lookup_en_i;
  logic        pred_valid_o;
  logic [31:0] pred_next_pc_o;
  logic        update_valid_i;
  logic [31:0] update_pc_i;
  logic        update_taken_i;
  logic [31:0] update_target_i;
  logic [1:0]  update_kind_i;

  modport master (
    output lookup_pc_i, lookup_en_i,
    output update_valid_i, update_pc_i, update_taken_i, update_target_i, update_kind_i,
    input  pred_valid_o, pred_next_pc_o
  );

  modport slave (
    input  lookup_pc_i, lookup_en_i,
    input  update_valid_i, update_pc_i, update_taken_i, update_target_i, update_kind_i,
    output pred_valid_o, pred_next_pc_o
  );
endinterface

// File: rtl/branch_predictor.sv
// N-way set-associative BTB with saturating direction counters and per-set round-robin replacement.
// Define BP_RAS_EN to add a speculative return address stack driven by call/return BTB hits.
module branch_predictor #(
  parameter int unsigned ENTRIES   = 64,
  parameter int unsigned WAYS      = 2,
  parameter int unsigned CTR_BITS  = 2,
  parameter int unsigned TAG_BITS  = 12,
  parameter int unsigned RAS_DEPTH = 8
) (
  input logic                clk,
  input logic                rst,
  branch_predictor_if.slave  bp
);

  localparam int unsigned SETS  = ENTRIES / WAYS;
  localparam int unsigned IDX   = $clog2(SETS);
  localparam int unsigned IDX_W = (IDX > 0) ? IDX : 1;
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  typedef enum logic [1:0] {
    KIND_BRANCH = 2'b00,
    KIND_JUMP   = 2'b01,
    KIND_CALL   = 2'b10,
    KIND_RET    = 2'b11
  } kind_e;

  if (WAYS < 1 || WAYS > 8 || (WAYS & (WAYS - 1)) != 0 || ENTRIES < WAYS ||
      (ENTRIES & (ENTRIES - 1)) != 0 || CTR_BITS < 1 || CTR_BITS > 4 ||
      TAG_BITS < 1 || TAG_BITS > 30 - IDX ||
      RAS_DEPTH < 1 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("branch_predictor: illegal parameter combination");
  end

  function automatic logic [IDX_W-1:0] pc_index(input logic [31:0] pc);
    return IDX_W'((pc >> 2) % SETS);
  endfunction

  function automatic logic [TAG_BITS-1:0] pc_tag(input logic [31:0] pc);
    return TAG_BITS'(pc >> (IDX + 2));
  endfunction

  logic                valid_q  [SETS][WAYS];
  logic [TAG_BITS-1:0] tag_q    [SETS][WAYS];
  logic [31:0]         target_q [SETS][WAYS];
  logic [CTR_BITS-1:0] ctr_q    [SETS][WAYS];
  logic [WAY_W-1:0]    rr_q     [SETS];

  // ---------------- lookup ----------------
  logic [IDX_W-1:0]    lk_idx;
  logic [TAG_BITS-1:0] lk_tag;
  logic                lk_hit;
  logic [WAY_W-1:0]    lk_way;
  logic                lk_taken;
  logic [31:0]         lk_target;
  logic [31:0]         pc_plus4;

  always_comb begin
    lk_idx = pc_index(bp.lookup_pc_i);
    lk_tag = pc_tag(bp.lookup_pc_i);
    lk_hit = 1'b0;
    lk_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!lk_hit && valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
    end
  end

  assign lk_taken  = lk_hit && ctr_q[lk_idx][lk_way][CTR_BITS-1];
  assign lk_target = target_q[lk_idx][lk_way];
  assign pc_plus4  = bp.lookup_pc_i + 32'd4;
  assign bp.pred_valid_o = lk_taken;

  // ---------------- training ----------------
  logic [IDX_W-1:0]    up_idx;
  logic [TAG_BITS-1:0] up_tag;
  logic                up_hit;
  logic [WAY_W-1:0]    up_way;
  logic                inv_found;
  logic [WAY_W-1:0]    inv_way;
  logic                ent_we;
  logic [WAY_W-1:0]    ent_way;
  logic [31:0]         ent_target_d;
  logic [CTR_BITS-1:0] ent_ctr_d;
  logic                rr_we;
  logic [WAY_W-1:0]    rr_d;
  logic [CTR_BITS-1:0] up_ctr;

  always_comb begin
    up_idx    = pc_index(bp.update_pc_i);
    up_tag    = pc_tag(bp.update_pc_i);
    up_hit    = 1'b0;
    up_way    = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!up_hit && valid_q[up_idx][w] && tag_q[up_idx][w] == up_tag) begin
        up_hit = 1'b1;
        up_way = WAY_W'(w);
      end
      if (!inv_found && !valid_q[up_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign up_ctr = ctr_q[up_idx][up_way];

  always_comb begin
    ent_we       = 1'b0;
    ent_way      = up_way;
    ent_target_d = bp.update_target_i;
    ent_ctr_d    = CTR_WEAK;
    rr_we        = 1'b0;
    rr_d         = (rr_q[up_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[up_idx] + 1'b1;
    if (bp.update_valid_i) begin
      if (up_hit) begin
        ent_we = 1'b1;
        if (!bp.update_taken_i) begin
          ent_target_d = target_q[up_idx][up_way];
          ent_ctr_d    = (up_ctr == '0) ? '0 : up_ctr - 1'b1;
        end else if (bp.update_target_i == target_q[up_idx][up_way]) begin
          ent_ctr_d = (up_ctr == CTR_MAX) ? CTR_MAX : up_ctr + 1'b1;
        end
      end else if (bp.update_taken_i) begin
        ent_we = 1'b1;
        if (inv_found) begin
          ent_way = inv_way;
        end else begin
          ent_way = rr_q[up_idx];
          rr_we   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
          valid_q[s][w]  <= 1'b0;
          tag_q[s][w]    <= '0;
          target_q[s][w] <= '0;
          ctr_q[s][w]    <= '0;
        end
      end
    end else begin
      if (ent_we) begin
        valid_q[up_idx][ent_way]  <= 1'b1;
        tag_q[up_idx][ent_way]    <= up_tag;
        target_q[up_idx][ent_way] <= ent_target_d;
        ctr_q[up_idx][ent_way]    <= ent_ctr_d;
      end
      if (rr_we) begin
        rr_q[up_idx] <= rr_d;
      end
    end
  end

`ifdef BP_RAS_EN
  localparam int unsigned RAS_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = RAS_W + 1;

  function automatic logic [RAS_W-1:0] ras_inc(input logic [RAS_W-1:0] p);
    return (p == RAS_W'(RAS_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [RAS_W-1:0] ras_dec(input logic [RAS_W-1:0] p);
    return (p == '0) ? RAS_W'(RAS_DEPTH - 1) : p - 1'b1;
  endfunction

  // kind only matters for prediction when the RAS exists, so it is kept only here
  kind_e               kind_q   [SETS][WAYS];
  logic [31:0]         ras_q    [RAS_DEPTH];
  logic [RAS_W-1:0]    ras_sp_q;
  logic [CNT_W-1:0]    ras_cnt_q;
  kind_e               lk_kind;
  logic                ras_use;
  logic                ras_push;
  logic                ras_pop;

  assign lk_kind  = kind_q[lk_idx][lk_way];
  assign ras_use  = lk_taken && lk_kind == KIND_RET && ras_cnt_q != '0;
  assign ras_push = bp.lookup_en_i && lk_taken && lk_kind == KIND_CALL;
  assign ras_pop  = bp.lookup_en_i && ras_use;
  assign bp.pred_next_pc_o = !lk_taken ? pc_plus4 :
                             ras_use   ? ras_q[ras_dec(ras_sp_q)] : lk_target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          kind_q[s][w] <= KIND_BRANCH;
        end
      end
    end else if (ent_we) begin
      kind_q[up_idx][ent_way] <= kind_e'(bp.update_kind_i);
    end
  end

  // Circular stack: overflow silently overwrites the oldest slot, count saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ras_sp_q  <= '0;
      ras_cnt_q <= '0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else if (ras_push) begin
      ras_q[ras_sp_q] <= pc_plus4;
      ras_sp_q        <= ras_inc(ras_sp_q);
      if (ras_cnt_q != CNT_W'(RAS_DEPTH)) begin
        ras_cnt_q <= ras_cnt_q + 1'b1;
      end
    end else if (ras_pop) begin
      ras_sp_q  <= ras_dec(ras_sp_q);
      ras_cnt_q <= ras_cnt_q - 1'b1;
    end
  end
`else
  assign bp.pred_next_pc_o = lk_taken ? lk_target : pc_plus4;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic against a reference model.
module tb_branch_predictor;
  localparam int unsigned ENTRIES   = 64;
  localparam int unsigned WAYS      = 2;
  localparam int unsigned CTR_BITS  = 2;
  localparam int unsigned TAG_BITS  = 12;
  localparam int unsigned RAS_DEPTH = 8;
  localparam int unsigned SETS      = ENTRIES / WAYS;
  localparam int          CTR_HALF  = 1 << (CTR_BITS - 1);
  localparam int          CTR_TOP   = (1 << CTR_BITS) - 1;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  branch_predictor_if bp_if ();

  branch_predictor #(
    .ENTRIES  (ENTRIES),
    .WAYS     (WAYS),
    .CTR_BITS (CTR_BITS),
    .TAG_BITS (TAG_BITS),
    .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bp (bp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit        m_valid  [SETS][WAYS];
  bit [31:0] m_tag    [SETS][WAYS];
  bit [31:0] m_target [SETS][WAYS];
  int        m_ctr    [SETS][WAYS];
  int        m_kind   [SETS][WAYS];
  int        m_rr     [SETS];
  bit [31:0] m_ras    [$];
  bit        m_push_pending;
  bit        m_pop_pending;
  bit [31:0] m_push_val;
  bit        obs_pv;
  bit [31:0] obs_npc;

  function automatic int m_set(input bit [31:0] pc);
    return int'((pc / 4) % SETS);
  endfunction

  function automatic bit [31:0] m_tagof(input bit [31:0] pc);
    return (pc / (4 * SETS)) % (32'd1 << TAG_BITS);
  endfunction

  function automatic int m_find(input bit [31:0] pc);
    int s;
    s = m_set(pc);
    for (int w = 0; w < int'(WAYS); w++)
      if (m_valid[s][w] && m_tag[s][w] == m_tagof(pc)) return w;
    return -1;
  endfunction

  task automatic m_reset();
    for (int s = 0; s < int'(SETS); s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < int'(WAYS); w++) begin
        m_valid[s][w] = 0;
        m_ctr[s][w]   = 0;
      end
    end
    m_ras.delete();
    m_push_pending = 0;
    m_pop_pending  = 0;
  endtask

  task automatic m_predict(input bit [31:0] pc, input bit en, output bit pv, output bit [31:0] npc);
    int s, w;
    s = m_set(pc);
    w = m_find(pc);
    pv = (w >= 0) && (m_ctr[s][w] >= CTR_HALF);
    npc = pv ? m_target[s][w] : pc + 32'd4;
    m_push_pending = 0;
    m_pop_pending  = 0;
`ifdef BP_RAS_EN
    if (pv && m_kind[s][w] == 2 && en) begin
      m_push_pending = 1;
      m_push_val     = pc + 32'd4;
    end
    if (pv && m_kind[s][w] == 3 && m_ras.size() > 0) begin
      npc = m_ras[$];
      m_pop_pending = en;
    end
`endif
  endtask

  task automatic m_apply_ras();
    if (m_push_pending) begin
      m_ras.push_back(m_push_val);
      if (m_ras.size() > int'(RAS_DEPTH)) void'(m_ras.pop_front());
    end
    if (m_pop_pending) void'(m_ras.pop_back());
  endtask

  task automatic m_update(input bit [31:0] pc, input bit taken, input bit [31:0] tgt, input int kind);
    int s, w;
    s = m_set(pc);
    w = m_find(pc);
    if (w >= 0) begin
      if (!taken) m_ctr[s][w] = (m_ctr[s][w] > 0) ? m_ctr[s][w] - 1 : 0;
      else if (tgt != m_target[s][w]) begin
        m_target[s][w] = tgt;
        m_ctr[s][w]    = CTR_HALF;
      end else m_ctr[s][w] = (m_ctr[s][w] < CTR_TOP) ? m_ctr[s][w] + 1 : CTR_TOP;
      m_kind[s][w] = kind;
    end else if (taken) begin
      for (int i = int'(WAYS) - 1; i >= 0; i--) if (!m_valid[s][i]) w = i;
      if (w < 0) begin
        w = m_rr[s];
        m_rr[s] = (m_rr[s] + 1) % int'(WAYS);
      end
      m_valid[s][w]  = 1;
      m_tag[s][w]    = m_tagof(pc);
      m_target[s][w] = tgt;
      m_ctr[s][w]    = CTR_HALF;
      m_kind[s][w]   = kind;
    end
  endtask

  // ---------------- checking / stimulus ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit [31:0] lpc, input bit len, input bit uv, input bit [31:0] upc,
                      input bit ut, input bit [31:0] utgt, input bit [1:0] uk, input string tag);
    bit        e_pv;
    bit [31:0] e_npc;
    @(negedge clk);
    bp_if.lookup_pc_i     = lpc;
    bp_if.lookup_en_i     = len;
    bp_if.update_valid_i  = uv;
    bp_if.update_pc_i     = upc;
    bp_if.update_taken_i  = ut;
    bp_if.update_target_i = utgt;
    bp_if.update_kind_i   = uk;
    #2;
    m_predict(lpc, len, e_pv, e_npc);
    obs_pv  = bp_if.pred_valid_o;
    obs_npc = bp_if.pred_next_pc_o;
    check({tag, "_pv"}, {31'd0, obs_pv}, {31'd0, e_pv});
    check({tag, "_npc"}, obs_npc, e_npc);
    @(posedge clk);
    m_apply_ras();
    if (uv) m_update(upc, ut, utgt, int'(uk));
  endtask

  task automatic upd(input bit [31:0] pc, input bit taken, input bit [31:0] tgt, input bit [1:0] kind);
    step(32'h8000_0000, 1'b0, 1'b1, pc, taken, tgt, kind, "upd");
  endtask

  task automatic look(input bit [31:0] pc, input bit en, input string tag);
    step(pc, en, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, tag);
  endtask

  task automatic hard_reset();
    @(negedge clk);
    rst = 1'b1;
    bp_if.update_valid_i = 1'b0;
    bp_if.lookup_en_i    = 1'b0;
    #2;
    rst = 1'b0;
    m_reset();
  endtask

  function automatic bit [31:0] rnd_pc();
    if ($urandom_range(0, 9) < 8) return 32'h1000 + ($urandom_range(0, 127) << 2);
    return $urandom;
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    bp_if.lookup_pc_i     = 32'h8000_0000;
    bp_if.lookup_en_i     = 1'b0;
    bp_if.update_valid_i  = 1'b0;
    bp_if.update_pc_i     = '0;
    bp_if.update_taken_i  = 1'b0;
    bp_if.update_target_i = '0;
    bp_if.update_kind_i   = '0;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state
    look(32'h8000_0000, 1'b1, "t1");
    check("t1_const_pv", {31'd0, obs_pv}, 32'd0);
    check("t1_const_npc", obs_npc, 32'h8000_0004);

    // allocate then predict
    upd(32'h100, 1'b1, 32'h200, 2'b00);
    look(32'h100, 1'b1, "t2");
    check("t2_const_npc", obs_npc, 32'h200);

    // counter walks down and back up one step
    upd(32'h100, 1'b0, 32'h0, 2'b00);
    upd(32'h100, 1'b0, 32'h0, 2'b00);
    look(32'h100, 1'b1, "t3a");
    check("t3a_const_npc", obs_npc, 32'h104);
    upd(32'h100, 1'b1, 32'h200, 2'b00);
    look(32'h100, 1'b1, "t3b");
    check("t3b_const_pv", {31'd0, obs_pv}, 32'd0);

    // round-robin eviction in set 0
    hard_reset();
    upd(32'h100, 1'b1, 32'h1100, 2'b00);
    upd(32'h180, 1'b1, 32'h1180, 2'b00);
    upd(32'h200, 1'b1, 32'h1200, 2'b00);
    look(32'h180, 1'b1, "t4a");
    check("t4a_const_npc", obs_npc, 32'h1180);
    look(32'h200, 1'b1, "t4b");
    check("t4b_const_npc", obs_npc, 32'h1200);
    look(32'h100, 1'b1, "t4c");
    check("t4c_const_npc", obs_npc, 32'h104);
    upd(32'h280, 1'b1, 32'h1280, 2'b00);
    look(32'h180, 1'b1, "t4d");
    check("t4d_const_npc", obs_npc, 32'h184);

    // same-cycle update and lookup sees the old contents
    step(32'h300, 1'b1, 1'b1, 32'h300, 1'b1, 32'h3300, 2'b01, "t5a");
    check("t5a_const_pv", {31'd0, obs_pv}, 32'd0);
    look(32'h300, 1'b1, "t5b");
    check("t5b_const_npc", obs_npc, 32'h3300);

    // pc+4 wraps
    look(32'hFFFF_FFFC, 1'b1, "wrap");
    check("wrap_const_npc", obs_npc, 32'h0);

`ifdef BP_RAS_EN
    hard_reset();
    upd(32'h400, 1'b1, 32'h800, 2'b10);
    upd(32'h900, 1'b1, 32'h999, 2'b11);
    look(32'h900, 1'b1, "ras_empty");
    check("ras_empty_const", obs_npc, 32'h999);
    look(32'h400, 1'b1, "ras_call");
    look(32'h900, 1'b0, "ras_peek");
    check("ras_peek_const", obs_npc, 32'h404);
    look(32'h900, 1'b1, "ras_pop");
    look(32'h900, 1'b1, "ras_empty2");
    check("ras_empty2_const", obs_npc, 32'h999);
    for (int k = 1; k < 9; k++) upd(32'h400 + 32'(k * 4), 1'b1, 32'h800, 2'b10);
    for (int k = 0; k < 9; k++) look(32'h400 + 32'(k * 4), 1'b1, "ras_push");
    for (int k = 0; k < 8; k++) begin
      look(32'h900, 1'b1, "ras_ovf_pop");
      check("ras_ovf_const", obs_npc, 32'h424 - 32'(k * 4));
    end
    look(32'h900, 1'b1, "ras_lost");
    check("ras_lost_const", obs_npc, 32'h999);
`endif

    // randomized traffic, with an asynchronous reset partway through
    hard_reset();
    for (int i = 0; i < 800; i++) begin
      if (i == 400) begin
        @(negedge clk);
        bp_if.lookup_pc_i    = 32'h1010;
        bp_if.update_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_pv", {31'd0, bp_if.pred_valid_o}, 32'd0);
        check("midrst_npc", bp_if.pred_next_pc_o, 32'h1014);
        #1;
        rst = 1'b0;
        m_reset();
      end
      step(rnd_pc(), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6), rnd_pc(),
           ($urandom_range(0, 9) < 7), 32'h2000 + ($urandom_range(0, 3) << 2),
           2'($urandom_range(0, 3)), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
